hci_core_per_arbiter: RTL and testbench
=======================================

HCI_CORE_PER_ARBITER -- requirements
Module: hci_core_per_arbiter

Interface
REQ-001 SHALL have parameter NB_IN, default 4, number of requester ports (2..16).
REQ-002 SHALL have parameter MAX_OUTSTANDING, default 2, depth of the in-flight ID queue (power of two, >=1).
REQ-003 SHALL have parameter AW, default hci_package::DEFAULT_AW, address width; DW, UW, EW follow hci_package defaults.
REQ-004 clk_i  input  1  clock, rising edge.
REQ-005 rst_ni  input  1  reset, asynchronous, active-low.
REQ-006 clear_i  input  1  synchronous clear of all state.
REQ-007 in[NB_IN]  hci_core_intf.slave  -  requester ports, typically the per_master side of memory-map filters.
REQ-008 out  hci_core_intf.master  -  single shared peripheral port.
REQ-009 err_o  output  1  sticky: response arrived with empty ID queue.
REQ-010 busy_o  output  1  ID queue non-empty.

Function
REQ-011 SHALL arbitrate round-robin: candidates are in[i].req=1; search starts at rr_ptr, wraps NB_IN-1 -> 0.
REQ-012 SHALL lock the selection when out.req=1 and out.gnt=0; the locked index holds until its handshake or until that requester drops req.
REQ-013 out.req SHALL equal (any candidate) AND NOT full; add/wen/data/be/boffs/lrdy/user SHALL be muxed from the selected port, all zero when no candidate.
REQ-014 in[i].gnt SHALL be out.gnt AND out.req AND (i == selected); all other gnt 0; combinational, zero latency.
REQ-015 On handshake (out.req & out.gnt), rr_ptr SHALL become (winner+1) mod NB_IN and the winner index SHALL be pushed into the ID queue.
REQ-016 Every handshake, read or write, SHALL expect exactly one out.r_valid, in order, earliest one cycle after the grant.
REQ-017 On out.r_valid with queue non-empty: pop head, drive in[head].r_valid=1 and r_data/r_opc/r_user from out; all other ports r_valid=0, response fields 0.
REQ-018 On out.r_valid with queue empty: response dropped, no port sees r_valid, err_o set until rst_ni or clear_i.
REQ-019 Full (count==MAX_OUTSTANDING): out.req SHALL be forced 0 even if a pop occurs that cycle; no push/pop bypass.
REQ-020 Simultaneous push and pop when not full: count unchanged, both performed.
REQ-021 out.r_ready (lrdy) SHALL be passed from the selected requester only; response back-pressure is not supported.
REQ-022 clear_i SHALL empty the queue, set rr_ptr=0, drop the lock; err_o cleared; in-flight responses after clear are treated per REQ-018.

Reset
REQ-023 On rst_ni=0: rr_ptr=0, queue empty, lock cleared, err_o=0, busy_o=0, out.req=0, all in[i].gnt=0, all in[i].r_valid=0.
REQ-024 Reset mid-transaction SHALL discard pending IDs without producing any r_valid.

Structure
REQ-025 SHALL place no new typedefs in a package except hci_package constant HCI_PER_ARB_MAX_IN=16.
REQ-026 The ID queue SHALL be a sub-module hci_core_per_arbiter_idq (width $clog2(NB_IN), depth MAX_OUTSTANDING, push/pop/full/empty/head, clear).
REQ-027 The arbiter SHALL be flat combinational priority logic plus rr_ptr/lock registers in the top module.

Verification
REQ-028 in[0],in[2] req, gnt=1 continuous, r_valid 1 cycle later -> grants 0,2,0,2; r_data 0x11/0x22 delivered to in[0]/in[2] respectively.
REQ-029 in[1] req, out.gnt held 0 for 3 cycles while in[3] raises req -> out.add stays in[1].add; in[1] granted first, then in[3].
REQ-030 MAX_OUTSTANDING=2, 3 requesters, responses delayed 5 cycles -> third out.req=0 until first r_valid; busy_o=1; no push while full.
REQ-031 out.r_valid pulsed after reset with no request -> no in[i].r_valid, err_o=1, held until clear_i.
REQ-032 rst_ni asserted with 2 IDs queued, then r_valid -> all outputs at reset values, err_o=1 after release.
REQ-033 Random 10k-cycle run, NB_IN=4 -> each grant matched by exactly one response on the same port, in order; no starvation beyond NB_IN-1 grants.

Source files
------------

// File: rtl/hci_core_per_arbiter_pkg.sv
// Shared constants for the HCI core-side peripheral arbiter.
// Default bus widths and the largest supported requester count.
package hci_core_per_arbiter_pkg;
   localparam int HCI_PER_ARB_MAX_IN = 16;
   localparam int DEFAULT_AW         = 32;
   localparam int DEFAULT_DW         = 32;
   localparam int DEFAULT_UW         = 2;
   localparam int DEFAULT_EW         = 1;
endpackage

// File: rtl/hci_core_per_arbiter_if.sv
// HCI core bus bundle: request channel plus single-beat response channel.
interface hci_core_per_arbiter_if
   import hci_core_per_arbiter_pkg::*;
#(
   parameter int AW = DEFAULT_AW,
   parameter int DW = DEFAULT_DW,
   parameter int UW = DEFAULT_UW,
   parameter int EW = DEFAULT_EW
) ();
   // Handshake: a request transfers in the cycle where req and gnt are both 1;
   // req and its payload stay stable until then. r_valid is a one-cycle pulse
   // with no back-pressure, one per accepted request, in request order.
   logic          req;
   logic          gnt;
   logic [AW-1:0] add;
   logic          wen;
   logic [DW-1:0] data;
   logic [DW/8-1:0] be;
   logic [7:0]    boffs;
   logic          lrdy;
   logic [UW-1:0] user;
   logic [DW-1:0] r_data;
   logic          r_valid;
   logic [EW-1:0] r_opc;
   logic [UW-1:0] r_user;

   modport master (
      output req, add, wen, data, be, boffs, lrdy, user,
      input  gnt, r_data, r_valid, r_opc, r_user
   );

   modport slave (
      input  req, add, wen, data, be, boffs, lrdy, user,
      output gnt, r_data, r_valid, r_opc, r_user
   );
endinterface

// File: rtl/hci_core_per_arbiter_idq.sv
// In-flight requester ID queue: circular buffer, no push/pop bypass.
module hci_core_per_arbiter_idq #(
   parameter int W     = 2,
   parameter int DEPTH = 2
) (
   input  logic         clk_i,
   input  logic         rst_ni,
   input  logic         clear_i,
   input  logic         push_i,
   input  logic [W-1:0] data_i,
   input  logic         pop_i,
   output logic [W-1:0] head_o,
   output logic         full_o,
   output logic         empty_o
);
   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);
   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
   localparam logic [PW-1:0] LAST_C  = PW'(DEPTH - 1);

   logic [W-1:0]  mem_q [DEPTH];
   logic [W-1:0]  mem_d [DEPTH];
   logic [PW-1:0] wr_q, wr_d, rd_q, rd_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          do_push, do_pop;

   assign full_o  = (cnt_q == DEPTH_C);
   assign empty_o = (cnt_q == '0);
   assign do_push = push_i & ~full_o;
   assign do_pop  = pop_i & ~empty_o;
   assign head_o  = mem_q[rd_q];

   always_comb begin
      mem_d = mem_q;
      wr_d  = wr_q;
      rd_d  = rd_q;
      cnt_d = cnt_q;
      if (clear_i) begin
         wr_d  = '0;
         rd_d  = '0;
         cnt_d = '0;
      end else begin
         if (do_push) begin
            mem_d[wr_q] = data_i;
            wr_d = (wr_q == LAST_C) ? '0 : wr_q + 1'b1;
         end
         if (do_pop) begin
            rd_d = (rd_q == LAST_C) ? '0 : rd_q + 1'b1;
         end
         case ({do_push, do_pop})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
         endcase
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
         wr_q  <= '0;
         rd_q  <= '0;
         cnt_q <= '0;
      end else begin
         mem_q <= mem_d;
         wr_q  <= wr_d;
         rd_q  <= rd_d;
         cnt_q <= cnt_d;
      end
   end
endmodule

// File: rtl/hci_core_per_arbiter.sv
// Round-robin arbiter from NB_IN HCI requesters onto one peripheral port,
// routing in-order responses back through a queue of granted requester IDs.
module hci_core_per_arbiter
   import hci_core_per_arbiter_pkg::*;
#(
   parameter int NB_IN           = 4,
   parameter int MAX_OUTSTANDING = 2,
   parameter int AW              = DEFAULT_AW,
   parameter int DW              = DEFAULT_DW,
   parameter int UW              = DEFAULT_UW,
   parameter int EW              = DEFAULT_EW
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic                  clear_i,
   hci_core_per_arbiter_if.slave in [NB_IN],
   hci_core_per_arbiter_if.master out,
   output logic                  err_o,
   output logic                  busy_o
);
   localparam int IW = $clog2(NB_IN);
   localparam logic [IW-1:0] LAST_IDX = IW'(NB_IN - 1);

   if (NB_IN < 2 || NB_IN > HCI_PER_ARB_MAX_IN ||
       MAX_OUTSTANDING < 1 || (MAX_OUTSTANDING & (MAX_OUTSTANDING - 1)) != 0) begin : g_bad_param
      $error("hci_core_per_arbiter: unsupported NB_IN or MAX_OUTSTANDING");
   end

   logic [NB_IN-1:0] req, wen, lrdy, gnt, r_valid;
   logic [AW-1:0]    add   [NB_IN];
   logic [DW-1:0]    data  [NB_IN];
   logic [DW/8-1:0]  be    [NB_IN];
   logic [7:0]       boffs [NB_IN];
   logic [UW-1:0]    user  [NB_IN];

   logic [IW-1:0] rr_ptr_q, rr_ptr_d, lock_idx_q, lock_idx_d, sel, head;
   logic          lock_q, lock_d, err_q, err_d;
   logic          found, out_req, hs, full, empty;
   logic [IW:0]   cand;

   for (genvar i = 0; i < NB_IN; i++) begin : g_in
      assign req[i]   = in[i].req;
      assign add[i]   = in[i].add;
      assign wen[i]   = in[i].wen;
      assign data[i]  = in[i].data;
      assign be[i]    = in[i].be;
      assign boffs[i] = in[i].boffs;
      assign lrdy[i]  = in[i].lrdy;
      assign user[i]  = in[i].user;

      assign gnt[i]     = out.gnt & out_req & (sel == IW'(i));
      assign r_valid[i] = out.r_valid & ~empty & (head == IW'(i));

      assign in[i].gnt     = gnt[i];
      assign in[i].r_valid = r_valid[i];
      assign in[i].r_data  = r_valid[i] ? out.r_data : '0;
      assign in[i].r_opc   = r_valid[i] ? out.r_opc  : '0;
      assign in[i].r_user  = r_valid[i] ? out.r_user : '0;
   end

   // A stalled request keeps its winner so the payload on out cannot change
   // under a pending handshake, even if a higher-priority requester appears.
   always_comb begin
      sel   = rr_ptr_q;
      found = 1'b0;
      cand  = '0;
      if (lock_q && req[lock_idx_q]) begin
         sel   = lock_idx_q;
         found = 1'b1;
      end
      for (int k = 0; k < NB_IN; k++) begin
         cand = {1'b0, rr_ptr_q} + (IW+1)'(k);
         if (cand >= (IW+1)'(NB_IN)) cand = cand - (IW+1)'(NB_IN);
         if (!found && req[cand[IW-1:0]]) begin
            sel   = cand[IW-1:0];
            found = 1'b1;
         end
      end
   end

   assign out_req   = rst_ni & found & ~full;
   assign hs        = out_req & out.gnt;
   assign out.req   = out_req;
   assign out.add   = found ? add[sel]   : '0;
   assign out.wen   = found ? wen[sel]   : 1'b0;
   assign out.data  = found ? data[sel]  : '0;
   assign out.be    = found ? be[sel]    : '0;
   assign out.boffs = found ? boffs[sel] : '0;
   assign out.lrdy  = found ? lrdy[sel]  : 1'b0;
   assign out.user  = found ? user[sel]  : '0;

   hci_core_per_arbiter_idq #(
      .W     (IW),
      .DEPTH (MAX_OUTSTANDING)
   ) u_idq (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .clear_i (clear_i),
      .push_i  (hs),
      .data_i  (sel),
      .pop_i   (out.r_valid),
      .head_o  (head),
      .full_o  (full),
      .empty_o (empty)
   );

   always_comb begin
      rr_ptr_d   = rr_ptr_q;
      lock_d     = lock_q;
      lock_idx_d = lock_idx_q;
      err_d      = err_q;
      if (clear_i) begin
         rr_ptr_d   = '0;
         lock_d     = 1'b0;
         lock_idx_d = '0;
         err_d      = 1'b0;
      end else begin
         if (hs) rr_ptr_d = (sel == LAST_IDX) ? '0 : sel + 1'b1;
         lock_d     = out_req & ~out.gnt;
         lock_idx_d = sel;
         if (out.r_valid && empty) err_d = 1'b1;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         rr_ptr_q   <= '0;
         lock_q     <= 1'b0;
         lock_idx_q <= '0;
         err_q      <= 1'b0;
      end else begin
         rr_ptr_q   <= rr_ptr_d;
         lock_q     <= lock_d;
         lock_idx_q <= lock_idx_d;
         err_q      <= err_d;
      end
   end

   assign err_o  = err_q;
   assign busy_o = ~empty;
endmodule

// File: tb/tb_hci_core_per_arbiter.sv
// Bench for hci_core_per_arbiter: directed scenarios plus a random run, all
// checked cycle by cycle against a queue-based model of the arbitration rules.
module tb_hci_core_per_arbiter;
   import hci_core_per_arbiter_pkg::*;

   localparam int NB_IN   = 4;
   localparam int MAX_OUT = 2;
   localparam int AW = DEFAULT_AW;
   localparam int DW = DEFAULT_DW;
   localparam int UW = DEFAULT_UW;
   localparam int EW = DEFAULT_EW;
   localparam int IW = $clog2(NB_IN);

   // clock / reset
   logic clk_i = 1'b0;
   logic rst_ni = 1'b0;
   logic clear_i = 1'b0;
   logic err_o, busy_o;
   always #5 clk_i = ~clk_i;

   hci_core_per_arbiter_if #(.AW(AW), .DW(DW), .UW(UW), .EW(EW)) in_if [NB_IN] ();
   hci_core_per_arbiter_if #(.AW(AW), .DW(DW), .UW(UW), .EW(EW)) out_if ();

   hci_core_per_arbiter #(
      .NB_IN(NB_IN), .MAX_OUTSTANDING(MAX_OUT), .AW(AW), .DW(DW), .UW(UW), .EW(EW)
   ) dut (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .clear_i (clear_i),
      .in      (in_if),
      .out     (out_if),
      .err_o   (err_o),
      .busy_o  (busy_o)
   );

   // requester-side drivers and observers
   logic [NB_IN-1:0] drv_req = '0;
   logic [AW-1:0]    drv_add  [NB_IN];
   logic             drv_wen  [NB_IN];
   logic [DW-1:0]    drv_data [NB_IN];
   logic             drv_lrdy [NB_IN];
   logic [NB_IN-1:0] obs_gnt, obs_rvalid;
   logic [DW-1:0]    obs_rdata [NB_IN];

   // peripheral-side drivers
   logic          p_gnt = 1'b0;
   logic          p_rvalid = 1'b0;
   logic [DW-1:0] p_rdata = '0;

   for (genvar g = 0; g < NB_IN; g++) begin : g_port
      assign in_if[g].req   = drv_req[g];
      assign in_if[g].add   = drv_add[g];
      assign in_if[g].wen   = drv_wen[g];
      assign in_if[g].data  = drv_data[g];
      assign in_if[g].be    = '1;
      assign in_if[g].boffs = 8'(g);
      assign in_if[g].lrdy  = drv_lrdy[g];
      assign in_if[g].user  = UW'(g);
      assign obs_gnt[g]     = in_if[g].gnt;
      assign obs_rvalid[g]  = in_if[g].r_valid;
      assign obs_rdata[g]   = in_if[g].r_data;
   end

   assign out_if.gnt     = p_gnt;
   assign out_if.r_valid = p_rvalid;
   assign out_if.r_data  = p_rdata;
   assign out_if.r_opc   = '0;
   assign out_if.r_user  = '0;

   // scoreboard / reference model
   int n_checks = 0;
   int n_errors = 0;
   logic [IW-1:0] exp_q [$];
   int  m_ptr = 0;
   bit  m_lock = 0;
   int  m_lock_idx = 0;
   bit  m_err = 0;

   logic             last_oreq;
   logic [AW-1:0]    last_add;
   logic [NB_IN-1:0] last_gnt = '0, last_rv = '0;
   logic [DW-1:0]    last_rdata [NB_IN];

   bit track = 0;
   int wait_cnt [NB_IN];
   int starve_max = 0;
   int n_gnt_obs = 0, n_rsp_obs = 0;
   int pend_cnt = 0;

   task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: observed %0h expected %0h", tag, act, exp);
      end
   endtask

   function automatic void reset_model();
      exp_q.delete();
      m_ptr = 0;
      m_lock = 0;
      m_lock_idx = 0;
      m_err = 0;
   endfunction

   // One bus cycle: sample at the falling edge, compare against the model,
   // advance the model, then return just after the next rising edge.
   task automatic step();
      int winner, head;
      bit any, exp_oreq;
      logic [NB_IN-1:0] exp_gnt, exp_rv;
      @(negedge clk_i);
      if (!rst_ni) reset_model();
      last_oreq = out_if.req;
      last_add  = out_if.add;
      last_gnt  = obs_gnt;
      last_rv   = obs_rvalid;
      for (int i = 0; i < NB_IN; i++) last_rdata[i] = obs_rdata[i];

      any = (drv_req != '0);
      winner = 0;
      if (m_lock && drv_req[m_lock_idx]) winner = m_lock_idx;
      else for (int k = NB_IN - 1; k >= 0; k--)
         if (drv_req[(m_ptr + k) % NB_IN]) winner = (m_ptr + k) % NB_IN;
      exp_oreq = rst_ni && any && (exp_q.size() < MAX_OUT);
      exp_gnt  = (exp_oreq && p_gnt) ? (NB_IN'(1) << winner) : '0;
      head = -1;
      if (rst_ni && p_rvalid && exp_q.size() > 0) head = int'(exp_q[0]);
      exp_rv = (head >= 0) ? (NB_IN'(1) << head) : '0;

      check("out_req", out_if.req, exp_oreq);
      check("out_add", out_if.add, any ? drv_add[winner] : '0);
      check("out_wen", out_if.wen, any ? drv_wen[winner] : 1'b0);
      check("out_data", out_if.data, any ? drv_data[winner] : '0);
      check("out_lrdy", out_if.lrdy, any ? drv_lrdy[winner] : 1'b0);
      check("gnt", obs_gnt, exp_gnt);
      check("r_valid", obs_rvalid, exp_rv);
      for (int i = 0; i < NB_IN; i++)
         check($sformatf("r_data%0d", i), obs_rdata[i], (i == head) ? p_rdata : '0);
      check("err_o", err_o, m_err);
      check("busy_o", busy_o, exp_q.size() != 0);

      if (track) begin
         n_gnt_obs += $countones(obs_gnt);
         n_rsp_obs += $countones(obs_rvalid);
         for (int i = 0; i < NB_IN; i++) begin
            if (!drv_req[i] || obs_gnt[i]) wait_cnt[i] = 0;
            else if (obs_gnt != '0) wait_cnt[i]++;
            if (wait_cnt[i] > starve_max) starve_max = wait_cnt[i];
         end
      end

      if (!rst_ni || clear_i) begin
         reset_model();
      end else begin
         if (p_rvalid) begin
            if (exp_q.size() > 0) void'(exp_q.pop_front());
            else m_err = 1;
         end
         if (exp_oreq && p_gnt) begin
            exp_q.push_back(IW'(winner));
            m_ptr = (winner + 1) % NB_IN;
         end
         m_lock = exp_oreq && !p_gnt;
         m_lock_idx = winner;
      end
      @(posedge clk_i);
      #1;
   endtask

   logic [NB_IN-1:0] t28_gnt [4];
   logic [DW-1:0]    t28_dat [4];
   logic [NB_IN-1:0] t30_gnt [7];

   initial begin
      for (int i = 0; i < NB_IN; i++) begin
         drv_add[i] = '0; drv_wen[i] = 0; drv_data[i] = '0; drv_lrdy[i] = 0; wait_cnt[i] = 0;
      end
      t28_gnt = '{4'b0001, 4'b0100, 4'b0001, 4'b0100};
      t28_dat = '{32'h0, 32'h11, 32'h22, 32'h11};
      t30_gnt = '{4'b0001, 4'b0010, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0100};

      // reset with requests and grant present: nothing may leak out
      drv_req = 4'b1111;
      p_gnt = 1;
      step();
      step();
      check("rst_out_req", last_oreq, 1'b0);
      check("rst_gnt", last_gnt, '0);
      check("rst_busy", busy_o, 1'b0);
      drv_req = '0;
      p_gnt = 0;
      rst_ni = 1;
      step();

      // alternating grants 0,2,0,2 with one-cycle response latency
      drv_add[0] = 32'h100; drv_add[2] = 32'h200;
      drv_req = 4'b0101;
      p_gnt = 1;
      for (int c = 0; c < 4; c++) begin
         p_rvalid = (c > 0);
         p_rdata  = t28_dat[c];
         step();
         check($sformatf("t28_gnt%0d", c), last_gnt, t28_gnt[c]);
      end
      check("t28_rdata0", last_rdata[0], 32'h11);
      drv_req = '0;
      p_rvalid = 1;
      p_rdata = 32'h22;
      step();
      check("t28_rv_last", last_rv, 4'b0100);
      check("t28_rdata2", last_rdata[2], 32'h22);
      p_rvalid = 0;

      // stalled in[1] keeps the bus while in[3] joins
      drv_add[1] = 32'hA1; drv_add[3] = 32'hA3;
      p_gnt = 0;
      drv_req = 4'b0010;
      for (int c = 0; c < 3; c++) begin
         step();
         check($sformatf("t29_add%0d", c), last_add, 32'hA1);
         drv_req = 4'b1010;
      end
      p_gnt = 1;
      step();
      check("t29_first", last_gnt, 4'b0010);
      drv_req = 4'b1000;
      step();
      check("t29_second", last_gnt, 4'b1000);
      drv_req = '0;
      p_rvalid = 1;
      p_rdata = 32'h31;
      step();
      check("t29_rv1", last_rv, 4'b0010);
      p_rdata = 32'h33;
      step();
      check("t29_rv3", last_rv, 4'b1000);
      p_rvalid = 0;

      // queue full with late responses
      drv_req = 4'b0111;
      p_gnt = 1;
      for (int c = 0; c < 7; c++) begin
         p_rvalid = (c == 5);
         p_rdata = 32'h55;
         step();
         check($sformatf("t30_gnt%0d", c), last_gnt, t30_gnt[c]);
         if (c >= 2 && c <= 5) check($sformatf("t30_oreq%0d", c), last_oreq, 1'b0);
         if (c == 3) check("t30_busy", busy_o, 1'b1);
      end
      drv_req = '0;
      p_rvalid = 1;
      step();
      step();
      p_rvalid = 0;
      step();

      // stray response: sticky error until clear
      rst_ni = 0;
      step();
      rst_ni = 1;
      p_rvalid = 1;
      p_rdata = 32'hEE;
      step();
      check("t31_rv", last_rv, '0);
      p_rvalid = 0;
      check("t31_err", err_o, 1'b1);
      step();
      step();
      check("t31_err_held", err_o, 1'b1);
      clear_i = 1;
      step();
      clear_i = 0;
      check("t31_err_clr", err_o, 1'b0);

      // reset while two IDs are queued
      drv_req = 4'b0011;
      p_gnt = 1;
      step();
      step();
      check("t32_busy_pre", busy_o, 1'b1);
      drv_req = '0;
      rst_ni = 0;
      #1;
      check("t32_busy_rst", busy_o, 1'b0);
      check("t32_oreq_rst", out_if.req, 1'b0);
      p_rvalid = 1;
      step();
      check("t32_rv_rst", last_rv, '0);
      rst_ni = 1;
      step();
      check("t32_rv_after", last_rv, '0);
      p_rvalid = 0;
      check("t32_err", err_o, 1'b1);
      clear_i = 1;
      p_gnt = 0;
      step();
      clear_i = 0;

      // random run
      track = 1;
      for (int c = 0; c < 10000; c++) begin
         for (int i = 0; i < NB_IN; i++) begin
            if (drv_req[i] && !last_gnt[i]) begin
               if ($urandom_range(0, 19) == 0) drv_req[i] = 1'b0;
            end else begin
               drv_req[i] = 1'($urandom_range(0, 1));
               if (drv_req[i]) begin
                  drv_add[i]  = $urandom;
                  drv_wen[i]  = 1'($urandom_range(0, 1));
                  drv_data[i] = $urandom;
                  drv_lrdy[i] = 1'($urandom_range(0, 1));
               end
            end
         end
         p_gnt    = ($urandom_range(0, 3) != 0);
         p_rvalid = (pend_cnt > 0) && ($urandom_range(0, 1) == 1);
         p_rdata  = $urandom;
         step();
         pend_cnt = pend_cnt + ((last_oreq && p_gnt) ? 1 : 0) - (p_rvalid ? 1 : 0);
      end
      drv_req = '0;
      p_gnt = 0;
      for (int c = 0; c < 100 && pend_cnt > 0; c++) begin
         p_rvalid = 1;
         p_rdata = $urandom;
         step();
         pend_cnt--;
      end
      p_rvalid = 0;
      step();
      track = 0;
      check("drain_pending", pend_cnt, 0);
      check("grant_resp_balance", n_rsp_obs, n_gnt_obs);
      check("starvation_bound", starve_max <= NB_IN - 1, 1'b1);
      check("random_activity", n_gnt_obs > 1000, 1'b1);
      check("final_busy", busy_o, 1'b0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end
endmodule
